imem_loader: RTL

Boot-time program loader that sits directly upstream of the `cpu` core. It accepts a stream of 16-bit instruction words over a valid/ready handshake and writes them into instruction memory at consecutive halfword byte addresses. It holds the core in reset for the whole load and for a fixed drain interval afterwards, then releases it. The core's PC starts at 0 and steps by 2, so the loaded image is laid out to match.

---
 rtl/imem_loader_if.sv | 25 ++
 rtl/imem_loader.sv | 118 +++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// Boot-loader bus: control, instruction stream handshake and imem write port.
interface imem_loader_if;
  logic        start;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_last;
  logic        in_ready;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_rst;
  logic        done;
  logic        error;
  logic [15:0] word_count;

  modport slave (
    input  start, in_valid, in_data, in_last,
    output in_ready, imem_we, imem_addr, imem_wdata, cpu_rst, done, error, word_count
  );

  modport master (
    output start, in_valid, in_data, in_last,
    input  in_ready, imem_we, imem_addr, imem_wdata, cpu_rst, done, error, word_count
  );
endinterface

// File: rtl/imem_loader.sv
// Streams 16-bit instruction words into imem at halfword addresses and holds
// the core in reset until the image is loaded plus a fixed drain interval.
module imem_loader #(
  parameter int unsigned DEPTH          = 256,
  parameter int unsigned RELEASE_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.slave  bus
);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HOLD,
    ST_RUN,
    ST_ERROR
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        word_count_q, word_count_d;
  logic               imem_we_q, imem_we_d;
  logic [15:0]        imem_addr_q, imem_addr_d;
  logic [15:0]        imem_wdata_q, imem_wdata_d;
  logic               in_ready_q, in_ready_d;
  logic               cpu_rst_q, cpu_rst_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic               xfer;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    word_count_d = word_count_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    xfer         = bus.in_valid & in_ready_q;

    // start wins over any coincident transfer, which is dropped uncounted
    if (bus.start) begin
      state_d      = ST_LOAD;
      idx_d        = '0;
      word_count_d = '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (xfer) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = 16'({idx_q, 1'b0});
            imem_wdata_d = bus.in_data;
            idx_d        = idx_q + 1'b1;
            word_count_d = word_count_q + 16'd1;
            if (bus.in_last) begin
              state_d = ST_HOLD;
              cnt_d   = CNT_W'(RELEASE_CYCLES - 1);
            end else if (idx_q == IDX_W'(DEPTH - 1)) begin
              state_d = ST_ERROR;
            end
          end
        end
        ST_HOLD: begin
          if (cnt_q == '0) state_d = ST_RUN;
          else             cnt_d   = cnt_q - 1'b1;
        end
        default: ;
      endcase
    end

    // Outputs decode the next state so they are registered yet aligned with it
    in_ready_d = (state_d == ST_LOAD);
    cpu_rst_d  = (state_d != ST_RUN);
    done_d     = (state_d == ST_RUN);
    error_d    = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      word_count_q <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      in_ready_q   <= 1'b0;
      cpu_rst_q    <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      word_count_q <= word_count_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      in_ready_q   <= in_ready_d;
      cpu_rst_q    <= cpu_rst_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign bus.cpu_rst    = cpu_rst_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
  assign bus.word_count = word_count_q;
endmodule
